// File: rtl/oflow_dma_set_feeder_if.sv
// Bbox stream from the DMA and the set bus towards oflow_core, as seen by the set feeder.
// master = feeder side, slave = DMA/core side.
interface oflow_dma_set_feeder_if #(
    parameter int PE_NUM = 24,
    parameter int BBOX_W = 86,
    parameter int SET_W  = 2
);
    logic [BBOX_W-1:0]        bbox_in;
    logic                     bbox_in_valid;
    logic                     bbox_in_ready;
    logic [PE_NUM*BBOX_W-1:0] set_out;
    logic [PE_NUM-1:0]        set_valid_mask;
    logic                     new_frame;
    logic                     new_set_from_dma;
    logic                     ready_new_set;
    logic                     ready_new_frame;
    logic [SET_W-1:0]         set_idx;

    modport master (
        input  bbox_in, bbox_in_valid, ready_new_set, ready_new_frame,
        output bbox_in_ready, set_out, set_valid_mask, new_frame, new_set_from_dma, set_idx
    );

    modport slave (
        output bbox_in, bbox_in_valid, ready_new_set, ready_new_frame,
        input  bbox_in_ready, set_out, set_valid_mask, new_frame, new_set_from_dma, set_idx
    );
endinterface

// File: rtl/oflow_dma_set_feeder.sv
// Packs a frame's DMA bboxes into PE_NUM-wide sets and hands them to oflow_core,
// double-buffered so set k+1 is packed while the core works on set k.
module oflow_dma_set_feeder #(
    parameter int PE_NUM   = 24,
    parameter int BBOX_W   = 86,
    parameter int MAX_BBOX = 72,
    parameter int CNT_W    = $clog2(MAX_BBOX + 1),
    parameter int SET_W    = ($clog2((MAX_BBOX + PE_NUM - 1) / PE_NUM) < 1) ? 1
                             : $clog2((MAX_BBOX + PE_NUM - 1) / PE_NUM)
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic                  start_frame,
    input  logic [CNT_W-1:0]      cfg_num_bbox,
    oflow_dma_set_feeder_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err
);
    localparam int SLOT_W = $clog2(PE_NUM + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT_FRAME} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]  n_q, accepted_q;
    logic [SLOT_W-1:0] pack_slot_q;
    logic [SET_W:0]    sets_issued_q;
    logic [SET_W-1:0]  set_idx_q;
    logic [PE_NUM-1:0] mask_q, pack_mask;
    logic              core_rdy_q, rns_prev_q, rnf_prev_q;
    logic              busy_q, frame_done_q, cfg_err_q, new_frame_q, new_set_q;

    logic              cfg_over, all_accepted, pack_full, pack_complete, in_run;
    logic              issue, last_issue, in_ready, accept, rns_rise, rnf_rise;
    logic [CNT_W-1:0]  n_start;
    logic [SLOT_W-1:0] wr_slot;

    assign cfg_over      = cfg_num_bbox > CNT_W'(MAX_BBOX);
    assign n_start       = cfg_over ? CNT_W'(MAX_BBOX) : cfg_num_bbox;
    assign all_accepted  = (accepted_q == n_q);
    assign pack_full     = (pack_slot_q == SLOT_W'(PE_NUM));
    assign pack_complete = pack_full || all_accepted;
    assign in_run        = (state_q == ST_RUN);
    assign issue         = in_run && pack_complete && core_rdy_q;
    assign last_issue    = issue && all_accepted;
    // A full pack that is transferring this cycle frees slot 0 for the incoming beat.
    assign in_ready      = in_run && !all_accepted && (!pack_full || issue);
    assign accept        = in_ready && bus.bbox_in_valid;
    assign wr_slot       = issue ? '0 : pack_slot_q;
    assign rns_rise      = bus.ready_new_set & ~rns_prev_q;
    assign rnf_rise      = bus.ready_new_frame & ~rnf_prev_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start_frame && n_start != '0) state_d = ST_RUN;
            ST_RUN:        if (last_issue) state_d = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (rnf_rise) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_N) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset_N) begin
            n_q           <= '0;
            accepted_q    <= '0;
            pack_slot_q   <= '0;
            sets_issued_q <= '0;
            set_idx_q     <= '0;
            mask_q        <= '0;
            core_rdy_q    <= 1'b1;
            rns_prev_q    <= 1'b0;
            rnf_prev_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            new_frame_q   <= 1'b0;
            new_set_q     <= 1'b0;
        end else begin
            rns_prev_q   <= bus.ready_new_set;
            rnf_prev_q   <= bus.ready_new_frame;
            new_frame_q  <= 1'b0;
            new_set_q    <= 1'b0;
            frame_done_q <= 1'b0;

            if (start_frame) begin
                if (state_q == ST_IDLE) begin
                    n_q           <= n_start;
                    accepted_q    <= '0;
                    pack_slot_q   <= '0;
                    sets_issued_q <= '0;
                    if (cfg_over) cfg_err_q <= 1'b1;
                    if (n_start == '0) frame_done_q <= 1'b1;
                    else               busy_q       <= 1'b1;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            if (accept) accepted_q <= accepted_q + CNT_W'(1);
            if (in_run) pack_slot_q <= (issue ? '0 : pack_slot_q) + SLOT_W'(accept);

            if (in_run && sets_issued_q != '0 && rns_rise) core_rdy_q <= 1'b1;

            if (issue) begin
                set_idx_q     <= sets_issued_q[SET_W-1:0];
                sets_issued_q <= sets_issued_q + 1'b1;
                mask_q        <= pack_mask;
                core_rdy_q    <= 1'b0;
                if (sets_issued_q == '0) new_frame_q <= 1'b1;
                else                     new_set_q   <= 1'b1;
            end

            if (state_q == ST_WAIT_FRAME && rnf_rise) begin
                frame_done_q <= 1'b1;
                core_rdy_q   <= 1'b1;
                busy_q       <= 1'b0;
            end
        end
    end

    // Per-slot pack register and issued-set register.
    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_slot
        logic [BBOX_W-1:0] pack_q, set_q;

        always_ff @(posedge clk) begin
            if (reset_N) begin
                pack_q <= '0;
                set_q  <= '0;
            end else begin
                if (issue) begin
                    set_q  <= pack_q;
                    pack_q <= '0;
                end
                if (accept && wr_slot == SLOT_W'(gi)) pack_q <= bus.bbox_in;
            end
        end

        assign bus.set_out[gi*BBOX_W +: BBOX_W] = set_q;
        assign pack_mask[gi] = (pack_slot_q > SLOT_W'(gi));
    end

    assign bus.bbox_in_ready    = in_ready;
    assign bus.set_valid_mask   = mask_q;
    assign bus.new_frame        = new_frame_q;
    assign bus.new_set_from_dma = new_set_q;
    assign bus.set_idx          = set_idx_q;
    assign busy                 = busy_q;
    assign frame_done           = frame_done_q;
    assign cfg_err              = cfg_err_q;
endmodule

// File: doc/oflow_dma_set_feeder.md
Name: oflow_dma_set_feeder

Overview:
- Sits between the DMA bbox stream and oflow_core.
- Packs a frame's bboxes, one per cycle, into sets of PE_NUM and issues each set with a new_frame / new_set_from_dma pulse.
- Paces issue on the core's ready_new_set / ready_new_frame, pads partial final sets, and double-buffers so packing of set k+1 overlaps core processing of set k.

Parameters:
PE_NUM, 24, bboxes per set (PE count)
BBOX_W, 86, bbox vector width
MAX_BBOX, 72, max bboxes per frame
CNT_W, $clog2(MAX_BBOX+1), bbox counter width
SET_W, $clog2((MAX_BBOX+PE_NUM-1)/PE_NUM), set index width (min 1)

Ports:
clk  in  1  clock, rising edge
reset_N  in  1  synchronous reset, active-high (1 = reset)
start_frame  in  1  pulse, begins a frame
cfg_num_bbox  in  CNT_W  bboxes in frame, sampled on accepted start_frame
bbox_in  in  BBOX_W  bbox from DMA
bbox_in_valid  in  1  bbox_in valid
bbox_in_ready  out  1  feeder accepts bbox_in this cycle
set_out  out  PE_NUM*BBOX_W  packed set; slot i at [i*BBOX_W +: BBOX_W]
set_valid_mask  out  PE_NUM  bit i = slot i holds real bbox
new_frame  out  1  1-cycle pulse, first set of frame valid
new_set_from_dma  out  1  1-cycle pulse, subsequent set valid
ready_new_set  in  1  core ready for next set (rising edge used)
ready_new_frame  in  1  core finished frame (rising edge used)
set_idx  out  SET_W  index of set currently on set_out
busy  out  1  frame in progress
frame_done  out  1  1-cycle pulse, frame complete
cfg_err  out  1  sticky: clamp or start-while-busy; cleared by reset

Behaviour:
- Reset values: all outputs 0, including set_out, mask, pulses, bbox_in_ready and set_idx. core_rdy flag = 1. Edge-detect registers = 0.
- Reset mid-operation: counters, pack buffer, state and flags cleared; no pulse in the cycle after reset deasserts.
- States:
  - IDLE: bbox_in_ready=0. start_frame latches N = min(cfg_num_bbox, MAX_BBOX); cfg_err set if clamped. N=0 -> frame_done pulse next cycle, stay IDLE, no set pulses. Else go RUN, busy=1.
  - RUN: packing and issuing run concurrently (below). After the last set is issued -> WAIT_FRAME.
  - WAIT_FRAME: on ready_new_frame rising edge -> frame_done pulse next cycle, core_rdy=1, busy=0, IDLE.
- start_frame outside IDLE: ignored, cfg_err=1.
- Packing:
  - bbox_in_ready = RUN && pack not complete && accepted < N.
  - Beat accepted when valid && ready, written to slot pack_slot, which then increments.
  - Pack complete when pack_slot==PE_NUM or accepted==N.
  - Unfilled slots are zero; mask = (1<<pack_slot)-1.
- Issue: in a cycle where pack complete && core_rdy:
  - set_out/mask <= pack contents.
  - set_idx <= sets_issued; sets_issued increments.
  - pack buffer cleared, pack_slot <= 0, core_rdy <= 0.
  - Next cycle: new_frame if sets_issued was 0, else new_set_from_dma.
  - set_out held constant until the next issue.
- A bbox may be accepted into slot 0 in the same cycle the pack buffer transfers; the new beat is not lost.
- core_rdy is set by a ready_new_set rising edge while RUN with at least one set issued and not all issued, or by a ready_new_frame rising edge (see WAIT_FRAME).
- Edges outside those windows are ignored.
- Set count = ceil(N/PE_NUM); the last set is issued even if partial.
- Backpressure: with core_rdy=0, at most one set is on set_out plus one full pack; bbox_in_ready stays low until transfer.
- Pulses never overlap; only one of new_frame, new_set_from_dma or frame_done is high in any cycle.
- Arithmetic unsigned; counters never wrap (bounded by N ≤ MAX_BBOX).

Test Plan:
- N=72, PE_NUM=24, continuous valid, core edges 10 cycles after each pulse -> new_frame, then new_set_from_dma ×2; set_idx 0,1,2; masks all 0xFFFFFF; frame_done 1 cycle after ready_new_frame edge.
- N=50 -> 3 sets, last mask 0x000003, slots 2..23 of last set_out = 0, frame_done after ready_new_frame.
- cfg_num_bbox=0 -> frame_done exactly 1 cycle after start_frame, no new_frame, bbox_in_ready never 1.
- N=72, core withholds ready_new_set -> bbox_in_ready drops after 48 accepted beats; after the edge, set 1 issues and acceptance resumes; no beat lost, data order preserved per slot.
- reset_N=1 for 1 cycle mid set 1 -> next cycle all outputs 0, busy=0; a new start_frame with N=24 issues one set with new_frame (not new_set_from_dma).
- cfg_num_bbox=100 -> N clamped to 72, cfg_err=1, 3 sets issued; start_frame during RUN ignored, cfg_err stays 1.
